vote_tally_ctrl: RTL and testbench

Sequential plurality-vote controller. It accepts 2**M ballots one at a time over a valid/ready handshake and tallies them in 2**N per-candidate counters. It then scans the counters to pick the winner and presents the result with a valid/ack handshake. It is the serial, resource-shared counterpart to the combinational voting datapath, and it sequences collection, tally and result hand-off for an upstream ballot source.

---
 rtl/vote_pkg.sv | 16 +
 rtl/vote_tally_ctrl_if.sv | 36 +++
 rtl/vote_counter_bank.sv | 31 +++
 rtl/vote_tally_ctrl.sv | 130 +++++++++++++
 tb/tb_vote_tally_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared types, default sizes and derived widths for the vote tally controller
package vote_pkg;

  localparam int DEF_N    = 3;
  localparam int DEF_M    = 5;
  localparam int CAND_NUM = 2 ** DEF_N;
  localparam int CNT_W    = DEF_M + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    DONE    = 2'd3
  } vote_state_e;

endpackage

// File: rtl/vote_tally_ctrl_if.sv
// rtl/vote_tally_ctrl_if.sv - ballot/result handshake bundle; tie exists only with VOTE_TIE_DETECT_EN
interface vote_tally_ctrl_if #(
  parameter int N = vote_pkg::DEF_N,
  parameter int M = vote_pkg::DEF_M
);

  logic         start;
  logic         vote_valid;
  logic         vote_ready;
  logic [N-1:0] vote_in;
  logic         busy;
  logic         done_valid;
  logic         done_ack;
  logic [N-1:0] winner;
  logic [M:0]   winner_count;
`ifdef VOTE_TIE_DETECT_EN
  logic         tie;
`endif

  modport master (
    output start, vote_valid, vote_in, done_ack,
    input  vote_ready, busy, done_valid, winner, winner_count
`ifdef VOTE_TIE_DETECT_EN
    , input tie
`endif
  );

  modport slave (
    input  start, vote_valid, vote_in, done_ack,
    output vote_ready, busy, done_valid, winner, winner_count
`ifdef VOTE_TIE_DETECT_EN
    , output tie
`endif
  );

endinterface

// File: rtl/vote_counter_bank.sv
// rtl/vote_counter_bank.sv - per-candidate ballot counters with clear, one increment port and one read port
module vote_counter_bank
  import vote_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [N-1:0] inc_idx,
  input  logic [N-1:0] rd_idx,
  output logic [M:0]   rd_cnt
);

  logic [M:0] cnt [2**N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**N; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 2**N; i++) cnt[i] <= '0;
    end else if (inc_en) begin
      cnt[inc_idx] <= cnt[inc_idx] + (M+1)'(1);
    end
  end

  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/vote_tally_ctrl.sv
// rtl/vote_tally_ctrl.sv - serial plurality vote: collect 2**M ballots, scan 2**N counters, hand off winner
// Optional tie flag built when VOTE_TIE_DETECT_EN is defined.
module vote_tally_ctrl
  import vote_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic             clk,
  input  logic             rst_n,
  vote_tally_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_SCAN    = SCAN;
  localparam logic [1:0] ST_DONE    = DONE;

  localparam logic [M:0] LAST_BALLOT = (M+1)'(2**M - 1);

  logic [1:0]   state;
  logic [M:0]   ballot_cnt;
  logic [N-1:0] scan_idx;
  logic [N-1:0] best_idx, best_idx_nx, win_idx;
  logic [M:0]   best_cnt, best_cnt_nx, win_cnt;
  logic [M:0]   rd_cnt;
  logic         accept;
  logic         clr;

  assign accept = (state == ST_COLLECT) && bus.vote_valid;
  assign clr    = (state == ST_IDLE) && bus.start;

  vote_counter_bank #(.N(N), .M(M)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc_en  (accept),
    .inc_idx (bus.vote_in),
    .rd_idx  (scan_idx),
    .rd_cnt  (rd_cnt)
  );

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx_nx = best_idx;
    best_cnt_nx = best_cnt;
    if (rd_cnt > best_cnt) begin
      best_idx_nx = scan_idx;
      best_cnt_nx = rd_cnt;
    end
  end

`ifdef VOTE_TIE_DETECT_EN
  logic tie_q, tie_nx, win_tie;

  always_comb begin
    tie_nx = tie_q;
    if (rd_cnt > best_cnt) begin
      tie_nx = 1'b0;
    end else if ((rd_cnt == best_cnt) && (best_cnt != '0)) begin
      tie_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_q   <= 1'b0;
      win_tie <= 1'b0;
    end else if (clr) begin
      tie_q <= 1'b0;
    end else if (state == ST_SCAN) begin
      tie_q <= tie_nx;
      if (scan_idx == '1) win_tie <= tie_nx;
    end
  end

  assign bus.tie = win_tie;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ballot_cnt <= '0;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_cnt   <= '0;
      win_idx    <= '0;
      win_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state      <= ST_COLLECT;
            ballot_cnt <= '0;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_cnt   <= '0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            ballot_cnt <= ballot_cnt + (M+1)'(1);
            if (ballot_cnt == LAST_BALLOT) state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_idx <= best_idx_nx;
          best_cnt <= best_cnt_nx;
          scan_idx <= scan_idx + N'(1);
          if (scan_idx == '1) begin
            state   <= ST_DONE;
            win_idx <= best_idx_nx;
            win_cnt <= best_cnt_nx;
          end
        end
        ST_DONE: begin
          if (bus.done_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vote_ready   = (state == ST_COLLECT);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done_valid   = (state == ST_DONE);
  assign bus.winner       = win_idx;
  assign bus.winner_count = win_cnt;

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// tb/tb_vote_tally_ctrl.sv - randomized self-checking bench for vote_tally_ctrl (tie checked with VOTE_TIE_DETECT_EN)
module tb_vote_tally_ctrl;
  import vote_pkg::*;

  localparam int N  = DEF_N;
  localparam int M  = DEF_M;
  localparam int NC = 2 ** N;
  localparam int NB = 2 ** M;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vote_tally_ctrl_if #(.N(N), .M(M)) bus ();

  vote_tally_ctrl #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int ballots[$];
  int exp_win;
  int exp_cnt;
  int exp_tie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plurality result from the ballot list: max count, lowest id holding it, and how many hold it.
  function automatic void model();
    int tally[NC];
    int mx;
    int holders;
    foreach (tally[c]) tally[c] = 0;
    foreach (ballots[i]) tally[ballots[i]]++;
    mx = 0;
    foreach (tally[c]) if (tally[c] > mx) mx = tally[c];
    holders = 0;
    exp_win = -1;
    foreach (tally[c]) begin
      if (tally[c] == mx) begin
        holders++;
        if (exp_win < 0) exp_win = c;
      end
    end
    exp_cnt = mx;
    exp_tie = (holders >= 2) ? 1 : 0;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(bus.vote_ready), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done_valid"}, 32'(bus.done_valid), 0);
    check({tag, "_winner"}, 32'(bus.winner), 0);
    check({tag, "_winner_count"}, 32'(bus.winner_count), 0);
`ifdef VOTE_TIE_DETECT_EN
    check({tag, "_tie"}, 32'(bus.tie), 0);
`endif
  endtask

  // Offers ballots[0..n-1]; gap_mode 0 = back-to-back, 1 = every other cycle, 2 = random.
  task automatic feed(input int n, input int gap_mode, input bit poke, output int acc);
    int i;
    int cyc;
    logic rdy;
    logic v;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      rdy = bus.vote_ready;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.vote_valid = v;
      bus.vote_in    = N'(ballots[i]);
      bus.start      = poke && ($urandom_range(0, 3) == 0);
      if (v && rdy) i++;
    end
    acc = i;
  endtask

  task automatic run_election(input string tag, input int gap_mode, input bit poke, input int hold);
    int acc;
    int lat;
    int stable;
    logic [N-1:0] w0;
    logic [M:0]   c0;
    model();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 1);
    check({tag, "_ready"}, 32'(bus.vote_ready), 1);
    feed(NB, gap_mode, poke, acc);
    check({tag, "_accepts"}, 32'(acc), 32'(NB));
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_ready_drop"}, 32'(bus.vote_ready), 0);
      if (bus.done_valid) break;
      bus.vote_valid = 1'b1;
      bus.vote_in    = N'($urandom);
      bus.start      = poke && ($urandom_range(0, 1) == 0);
    end
    bus.vote_valid = 1'b0;
    bus.start      = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(NC + 1));
    check({tag, "_winner"}, 32'(bus.winner), 32'(exp_win));
    check({tag, "_count"}, 32'(bus.winner_count), 32'(exp_cnt));
`ifdef VOTE_TIE_DETECT_EN
    check({tag, "_tie"}, 32'(bus.tie), 32'(exp_tie));
`endif
    w0 = bus.winner;
    c0 = bus.winner_count;
    stable = 1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!bus.done_valid || bus.winner !== w0 || bus.winner_count !== c0) stable = 0;
      bus.start = poke && ($urandom_range(0, 1) == 0);
    end
    check({tag, "_hold"}, 32'(stable), 1);
    bus.start    = 1'b0;
    bus.done_ack = 1'b1;
    @(negedge clk);
    bus.done_ack = 1'b0;
    check({tag, "_idle_done_valid"}, 32'(bus.done_valid), 0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 0);
    check({tag, "_idle_winner"}, 32'(bus.winner), 32'(exp_win));
    check({tag, "_idle_count"}, 32'(bus.winner_count), 32'(exp_cnt));
  endtask

  initial begin
    int fixed[32] = '{5,7,5,4,0,7,0,5,3,3,1,2,2,1,4,2,3,5,6,0,5,5,7,1,6,3,5,5,3,1,7,2};
    int acc;
    int fav;

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.vote_valid = 1'b0;
    bus.vote_in    = '0;
    bus.done_ack   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    ballots.delete();
    foreach (fixed[i]) ballots.push_back(fixed[i]);
    run_election("fixed", 0, 1'b0, 2);

    ballots.delete();
    for (int i = 0; i < 16; i++) begin
      ballots.push_back(6);
      ballots.push_back(2);
    end
    run_election("tie62", 0, 1'b0, 1);

    ballots.delete();
    for (int i = 0; i < NB; i++) ballots.push_back(0);
    run_election("zeros_gap", 1, 1'b0, 1);

    ballots.delete();
    for (int i = 0; i < NB; i++) ballots.push_back($urandom_range(0, NC - 1));
    run_election("poke", 2, 1'b1, 20);

    ballots.delete();
    for (int i = 0; i < NB; i++) ballots.push_back(7);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    feed(10, 0, 1'b0, acc);
    check("abort_accepts", 32'(acc), 10);
    @(negedge clk);
    bus.vote_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;

    ballots.delete();
    for (int i = 0; i < NB; i++) ballots.push_back(4);
    run_election("after_abort", 0, 1'b0, 1);

    for (int e = 0; e < 6; e++) begin
      fav = $urandom_range(0, NC - 1);
      ballots.delete();
      for (int i = 0; i < NB; i++)
        ballots.push_back(($urandom_range(0, 2) == 0) ? fav : $urandom_range(0, NC - 1));
      run_election($sformatf("rand%0d", e), 2, e[0], $urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
